// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - multiplexed N-digit seven-segment driver with frame-aligned double buffering
module seg_display_mux #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  hex_mode,
    input  logic                  lzb,
    input  logic                  en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  load_ack
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;
    localparam logic [6:0]    SEG_DASH  = 7'b0111111;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [N_DIGITS-1:0]   shdp_q, shdp_d;
    logic [4*N_DIGITS-1:0] pend_q, pend_d;
    logic [N_DIGITS-1:0]   pdp_q, pdp_d;
    logic                  pend_v_q, pend_v_d;
    logic                  swap_q, swap_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  ack_q;

    logic                  tick;
    logic                  frame;
    logic [3:0]            cur_digit;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [N_DIGITS-1:0]   blank_vec;

    function automatic logic [6:0] decode(input logic [3:0] d, input logic hex);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = hex ? 7'b0001000 : SEG_DASH;
            4'hB: s = hex ? 7'b0000011 : SEG_DASH;
            4'hC: s = hex ? 7'b1000110 : SEG_DASH;
            4'hD: s = hex ? 7'b0100001 : SEG_DASH;
            4'hE: s = hex ? 7'b0000110 : SEG_DASH;
            default: s = hex ? 7'b0001110 : SEG_DASH;
        endcase
        return s;
    endfunction

    assign tick  = (presc_q == PRESC_MAX);
    assign frame = tick && (idx_q == IDX_MAX);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // A load landing on the boundary bypasses pending so it is not delayed a full frame.
    always_comb begin
        pend_d   = pend_q;
        pdp_d    = pdp_q;
        pend_v_d = pend_v_q;
        shadow_d = shadow_q;
        shdp_d   = shdp_q;
        swap_d   = 1'b0;
        if (frame && load) begin
            shadow_d = value_in;
            shdp_d   = dp_in;
            pend_v_d = 1'b0;
            swap_d   = 1'b1;
        end else if (frame && pend_v_q) begin
            shadow_d = pend_q;
            shdp_d   = pdp_q;
            pend_v_d = 1'b0;
            swap_d   = 1'b1;
        end else if (load) begin
            pend_d   = value_in;
            pdp_d    = dp_in;
            pend_v_d = 1'b1;
        end
    end

    // Scan from the most significant digit down; blanking stops at the first nonzero digit.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        blank_vec = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero && (shadow_q[4*k +: 4] == 4'h0);
            blank_vec[k] = all_zero && (k != 0);
        end
    end

    always_comb begin
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit = shadow_q[4*k +: 4];
                cur_dp    = shdp_q[k];
                cur_blank = blank_vec[k];
            end
        end
    end

    always_comb begin
        seg_d = (lzb && cur_blank) ? SEG_BLANK : decode(cur_digit, hex_mode);
        dp_d  = ~cur_dp;
        an_d  = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            an_d[k] = !(en && (idx_q == IW'(k)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            shdp_q   <= '0;
            pend_q   <= '0;
            pdp_q    <= '0;
            pend_v_q <= 1'b0;
            swap_q   <= 1'b0;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            an_q     <= '1;
            ack_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            shdp_q   <= shdp_d;
            pend_q   <= pend_d;
            pdp_q    <= pdp_d;
            pend_v_q <= pend_v_d;
            swap_q   <= swap_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            ack_q    <= swap_q;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign load_ack = ack_q;

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Multiplexed N-digit seven-segment display driver for the board's common-anode displays. It decodes each 4-bit digit to an active-low segment pattern in BCD or hexadecimal mode, with optional leading-zero blanking. It scans the digits by time-multiplexing the anode lines. New display values are double-buffered, so an update takes effect only at a frame boundary and the display never tears mid-scan.

## Interface
- N_DIGITS, 4: number of digits scanned (≥1).
- REFRESH_DIV, 100000: clock cycles each digit stays lit (≥1).
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe that captures value_in and dp_in.
- value_in  input  4*N_DIGITS  digit nibbles; digit k = value_in[4k+3:4k], digit 0 rightmost.
- dp_in  input  N_DIGITS  decimal point request per digit (1 = lit).
- hex_mode  input  1  1 = hex glyphs for 10–15; 0 = BCD, with 10–15 shown as dash.
- lzb  input  1  leading-zero blanking enable.
- en  input  1  display enable; 0 turns all anodes off.
- seg  output  7  {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- an  output  N_DIGITS  anode enables, active low, one-hot-low while scanning.
- load_ack  output  1  one-cycle pulse when a captured value becomes visible.

## Operation
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - `tick` is asserted when count = REFRESH_DIV-1. With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index `idx`:
  - Width max(1, clog2(N_DIGITS)).
  - On tick, idx advances; N_DIGITS-1 wraps to 0.
  - A frame boundary is a tick with idx = N_DIGITS-1.
- Buffering:
  - `load` copies value_in/dp_in into a pending register and sets pend_v. A load while pend_v=1 overwrites the pending value (latest wins).
  - At a frame boundary with pend_v=1: pending moves to shadow, pend_v clears, load_ack pulses next cycle.
  - If load coincides with a frame boundary, the incoming value goes straight to shadow, pend_v is left 0, and load_ack pulses.
- Decode for shadow digit at idx:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Hex: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - BCD mode 10–15: dash 0111111.
- Leading-zero blanking:
  - Applies when lzb=1.
  - Digit k blanks (seg=1111111) if all shadow digits k..N_DIGITS-1 are zero and k≠0. Digit 0 is never blanked.
  - dp is not affected by blanking.
- an = ~(1<<idx) when en=1; all ones when en=0. The prescaler and idx keep running while en=0.
- hex_mode, lzb and en are sampled live each cycle; they are not buffered.

## Timing
- seg, dp, an and load_ack are registered: 1-cycle latency from idx/shadow/mode changes.
- Reset values:
  - Outputs: seg=1111111, dp=1, an=all ones, load_ack=0.
  - Internal: prescaler=0, idx=0, shadow=0, pending=0, pend_v=0.
- After reset deasserts, the first clock edge drives digit 0 (with en=1). Each digit is lit for exactly REFRESH_DIV cycles.
- Worst-case load-to-visible delay is N_DIGITS*REFRESH_DIV cycles. load_ack is asserted on the same cycle the new shadow value first reaches the outputs.
- Reset asserted mid-frame forces the reset values immediately (asynchronous) and discards any pending value; no load_ack follows.
- N_DIGITS=1:
  - idx is a constant 0.
  - Every tick is a frame boundary.

## Test plan
- Reset values: assert reset mid-scan → seg=7F, an=all ones, dp=1 at once. After release, the first edge gives an=1110 with seg showing digit 0 of shadow=0 (1000000).
- BCD scan: N_DIGITS=4, REFRESH_DIV=3, load value_in=16'h1234, dp_in=4'b0010.
  - After the frame boundary, load_ack pulses once.
  - The display cycles an=1110/1101/1011/0111 with seg=0011001/0110000/0100100/1111001, 3 cycles each.
  - dp=0 only while an=1101.
- Invalid BCD: value_in=16'h00AF, hex_mode=0 → digits 0,1 show 0111111. Switching hex_mode=1 gives 0001110 (F) and 0001000 (A) with 1-cycle latency.
- Buffering: load 16'h1111 at mid-frame, then 16'h2222 before the boundary → only 2222 appears, with a single load_ack. A load on the exact boundary cycle is visible after one cycle, with ack.
- Leading-zero blanking: lzb=1, value_in=16'h0050 → digits 3,2 show 1111111, digit 1 shows 5, digit 0 shows 0. value_in=0 → only digit 0 is lit, showing 0.
- Enable: en=0 for 10 cycles → an=all ones. idx keeps advancing, so after en=1 the lit digit matches the free-running scan position.
